ulpi_link_arbiter: RTL

//  Link-side ULPI bus controller in the clk (ULPI 60 MHz) domain, ahead of the ULPI receive state machine.

---
 rtl/ulpi_link_arbiter.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ulpi_link_arbiter.sv
// Link-side ULPI bus arbiter: TX packet engine vs PHY register port.
// Define ULPI_ARB_RR_EN for round-robin grant (default: register port wins ties).
module ulpi_link_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       dir,
   input  logic       nxt,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       stp,
   input  logic       pkt_req,
   input  logic [3:0] pkt_pid,
   input  logic [7:0] pkt_byte,
   input  logic       pkt_valid,
   input  logic       pkt_last,
   output logic       pkt_ready,
   output logic       pkt_done,
   output logic       pkt_abort,
   input  logic       reg_req,
   input  logic       reg_wr,
   input  logic [5:0] reg_addr,
   input  logic [7:0] reg_wdata,
   output logic [7:0] reg_rdata,
   output logic       reg_done,
   output logic       reg_err,
   output logic       busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_PKT_CMD, S_PKT_DATA, S_PKT_STP,
      S_REG_CMD, S_REG_WDATA, S_REG_STP,
      S_RD_TURN, S_RD_DATA, S_RD_BACK, S_WAIT_DIR
   } state_t;

   localparam logic [7:0] LP_TMO = 8'(TIMEOUT_CYCLES);

   state_t     r_state;
   logic [7:0] r_tmo;
   logic       r_last;
   logic [7:0] r_data_out;
   logic       r_stp;
   logic       r_pkt_done;
   logic       r_pkt_abort;
   logic       r_reg_done;
   logic       r_reg_err;
   logic [7:0] r_reg_rdata;

   logic [7:0] w_pkt_cmd;
   logic [7:0] w_reg_cmd;
   logic [7:0] w_tmo_nxt;
   logic       w_tmo_hit;
   logic       w_grant_reg;

   assign w_pkt_cmd = {4'b0100, pkt_pid};
   assign w_reg_cmd = {(reg_wr ? 2'b10 : 2'b11), reg_addr};
   assign w_tmo_nxt = (r_tmo == 8'hFF) ? r_tmo : r_tmo + 8'd1;
   assign w_tmo_hit = (w_tmo_nxt == LP_TMO);

`ifdef ULPI_ARB_RR_EN
   logic r_rr_reg;
   logic w_rr_eff;

   // Pointer moves away from whichever requester just finished.
   always_comb begin
      w_rr_eff = r_rr_reg;
      if (r_pkt_done | r_pkt_abort)
         w_rr_eff = 1'b1;
      else if (r_reg_done)
         w_rr_eff = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!n_rst)
         r_rr_reg <= 1'b1;
      else
         r_rr_reg <= w_rr_eff;
   end

   assign w_grant_reg = reg_req & (~pkt_req | w_rr_eff);
`else
   assign w_grant_reg = reg_req;
`endif

   // data_out prefetches the FIFO head, so a pop happens as each byte is loaded.
   assign pkt_ready = nxt & ~dir & pkt_valid &
                      ((r_state == S_PKT_CMD) |
                       ((r_state == S_PKT_DATA) & ~r_last));

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state     <= S_IDLE;
         r_tmo       <= 8'h00;
         r_last      <= 1'b0;
         r_data_out  <= 8'h00;
         r_stp       <= 1'b0;
         r_pkt_done  <= 1'b0;
         r_pkt_abort <= 1'b0;
         r_reg_done  <= 1'b0;
         r_reg_err   <= 1'b0;
         r_reg_rdata <= 8'h00;
      end else begin
         r_stp       <= 1'b0;
         r_pkt_done  <= 1'b0;
         r_pkt_abort <= 1'b0;
         r_reg_done  <= 1'b0;
         r_reg_err   <= 1'b0;
         r_tmo       <= 8'h00;
         r_data_out  <= 8'h00;
         unique case (r_state)
            S_IDLE: begin
               if (!dir) begin
                  if (w_grant_reg) begin
                     r_state    <= S_REG_CMD;
                     r_data_out <= w_reg_cmd;
                  end else if (pkt_req) begin
                     r_state    <= S_PKT_CMD;
                     r_data_out <= w_pkt_cmd;
                  end
               end
            end
            S_PKT_CMD: begin
               if (dir) begin
                  r_state <= S_WAIT_DIR;
               end else if (nxt) begin
                  if (!pkt_valid) begin
                     r_state     <= S_IDLE;
                     r_stp       <= 1'b1;
                     r_data_out  <= 8'hFF;
                     r_pkt_abort <= 1'b1;
                  end else begin
                     r_state    <= S_PKT_DATA;
                     r_data_out <= pkt_byte;
                     r_last     <= pkt_last;
                  end
               end else if (w_tmo_hit) begin
                  r_state     <= S_IDLE;
                  r_pkt_abort <= 1'b1;
               end else begin
                  r_data_out <= w_pkt_cmd;
                  r_tmo      <= w_tmo_nxt;
               end
            end
            S_PKT_DATA: begin
               if (dir) begin
                  r_state     <= S_WAIT_DIR;
                  r_pkt_abort <= 1'b1;
               end else if (!nxt) begin
                  r_data_out <= r_data_out;
               end else if (r_last) begin
                  r_state <= S_PKT_STP;
                  r_stp   <= 1'b1;
               end else if (!pkt_valid) begin
                  r_state     <= S_IDLE;
                  r_stp       <= 1'b1;
                  r_data_out  <= 8'hFF;
                  r_pkt_abort <= 1'b1;
               end else begin
                  r_data_out <= pkt_byte;
                  r_last     <= pkt_last;
               end
            end
            S_PKT_STP: begin
               r_state    <= S_IDLE;
               r_pkt_done <= 1'b1;
            end
            S_REG_CMD: begin
               if (dir) begin
                  r_state <= S_WAIT_DIR;
               end else if (nxt) begin
                  if (reg_wr) begin
                     r_state    <= S_REG_WDATA;
                     r_data_out <= reg_wdata;
                  end else begin
                     r_state <= S_RD_TURN;
                  end
               end else if (w_tmo_hit) begin
                  r_state    <= S_IDLE;
                  r_reg_done <= 1'b1;
                  r_reg_err  <= 1'b1;
               end else begin
                  r_data_out <= w_reg_cmd;
                  r_tmo      <= w_tmo_nxt;
               end
            end
            S_REG_WDATA: begin
               if (dir) begin
                  r_state <= S_REG_CMD;
               end else if (nxt) begin
                  r_state <= S_REG_STP;
                  r_stp   <= 1'b1;
               end else begin
                  r_data_out <= reg_wdata;
               end
            end
            S_REG_STP: begin
               r_state    <= S_IDLE;
               r_reg_done <= 1'b1;
            end
            S_RD_TURN: begin
               if (dir) begin
                  r_state <= S_RD_DATA;
               end else if (w_tmo_hit) begin
                  r_state    <= S_IDLE;
                  r_reg_done <= 1'b1;
                  r_reg_err  <= 1'b1;
               end else begin
                  r_tmo <= w_tmo_nxt;
               end
            end
            S_RD_DATA: begin
               r_state     <= S_RD_BACK;
               r_reg_rdata <= data_in;
            end
            S_RD_BACK: begin
               if (!dir) begin
                  r_state    <= S_IDLE;
                  r_reg_done <= 1'b1;
               end
            end
            S_WAIT_DIR: begin
               if (!dir)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data_out  = r_data_out;
   assign stp       = r_stp;
   assign pkt_done  = r_pkt_done;
   assign pkt_abort = r_pkt_abort;
   assign reg_done  = r_reg_done;
   assign reg_err   = r_reg_err;
   assign reg_rdata = r_reg_rdata;
   assign busy      = (r_state != S_IDLE);

endmodule
